// File: rtl/mc_maindec_pkg.sv
// Shared constants for the multicycle main decoder: state encodings, opcodes,
// datapath select codes and the control-word bundle.
package mc_maindec_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrlword.sv
// Moore output decode: maps the current state to the datapath control word.
module mc_ctrlword
  import mc_maindec_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
      end
      DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      MEMRD: ctrl_o.iord = 1'b1;
      MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      ADDIWB: ctrl_o.regwrite = 1'b1;
      BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_REG;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: state register and next-state logic; control word
// decoded from state by mc_ctrlword, with write strobes masked during reset.
module mc_maindec
  import mc_maindec_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       branch,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        case (op)
          OP_LW:   state_d = MEMRD;
          OP_SW:   state_d = MEMWR;
          default: state_d = FETCH;
        endcase
      end
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  mc_ctrlword u_ctrlword (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // Strobes are suppressed combinationally while reset is held; selects follow state.
  assign pcwrite  = ctrl.pcwrite  & ~reset;
  assign memwrite = ctrl.memwrite & ~reset;
  assign irwrite  = ctrl.irwrite  & ~reset;
  assign regwrite = ctrl.regwrite & ~reset;
  assign branch   = ctrl.branch   & ~reset;
  assign alusrca  = ctrl.alusrca;
  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign aluop    = ctrl.aluop;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: per-instruction state paths planned at FETCH,
// expected control words queued by the stimulus and checked by a monitor.
module tb_mc_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, memwrite, irwrite, regwrite, alusrca, branch;
  logic       iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  mc_maindec dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .pcwrite  (pcwrite),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .branch   (branch),
    .iord     (iord),
    .memtoreg (memtoreg),
    .regdst   (regdst),
    .alusrcb  (alusrcb),
    .pcsrc    (pcsrc),
    .aluop    (aluop),
    .state    (state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  typedef struct { int st; logic [5:0] drv; } step_t;
  typedef struct { int st; logic [14:0] cw; } exp_t;
  typedef struct { logic [5:0] op; int rst_at; int rst_len; } dir_t;

  step_t plan[$];
  exp_t  sb[$];
  dir_t  dirq[$];
  int    errors = 0;
  int    checks = 0;
  int    arm_state = -1;
  int    arm_len = 0;
  int    rst_left = 0;
  bit    random_rst = 1'b0;

  // Expected control word, listed per state straight from the state descriptions.
  function automatic logic [14:0] exp_cw(int st, logic rst);
    logic pcw = 0, mw = 0, irw = 0, rw = 0, asa = 0, br = 0;
    logic io = 0, m2r = 0, rd = 0;
    logic [1:0] asb = 0, pcs = 0, aop = 0;
    case (st)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (rst) begin pcw = 0; mw = 0; irw = 0; rw = 0; br = 0; end
    return {pcw, mw, irw, rw, asa, br, io, m2r, rd, asb, pcs, aop};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  // Plans the remainder of one instruction; opa is seen in DECODE, opb in MEMADR.
  task automatic plan_instr(input logic [5:0] opa, input logic [5:0] opb);
    plan.push_back(step_t'{st: 1, drv: opa});
    if (opa == LW || opa == SW) begin
      plan.push_back(step_t'{st: 2, drv: opb});
      if (opb == LW) begin
        plan.push_back(step_t'{st: 3, drv: rnd_op()});
        plan.push_back(step_t'{st: 4, drv: rnd_op()});
      end else if (opb == SW) begin
        plan.push_back(step_t'{st: 5, drv: rnd_op()});
      end
    end else if (opa == RT) begin
      plan.push_back(step_t'{st: 6, drv: rnd_op()});
      plan.push_back(step_t'{st: 7, drv: rnd_op()});
    end else if (opa == BEQ) begin
      plan.push_back(step_t'{st: 8, drv: rnd_op()});
    end else if (opa == ADDI) begin
      plan.push_back(step_t'{st: 9, drv: rnd_op()});
      plan.push_back(step_t'{st: 10, drv: rnd_op()});
    end else if (opa == JMP) begin
      plan.push_back(step_t'{st: 11, drv: rnd_op()});
    end
  endtask

  task automatic one_cycle();
    logic rst;
    logic [5:0] opa, opb;
    logic [5:0] pick[7];
    @(negedge clk);
    rst = 1'b0;
    if (rst_left > 0) begin
      rst = 1'b1;
      rst_left--;
    end else if (arm_state >= 0 && plan[0].st == arm_state) begin
      rst = 1'b1;
      rst_left = arm_len - 1;
      arm_state = -1;
    end else if (random_rst && $urandom_range(0, 49) == 0) begin
      rst = 1'b1;
    end
    if (!rst && plan.size() == 1 && plan[0].st == 0) begin
      if (dirq.size() > 0) begin
        dir_t d = dirq.pop_front();
        opa = d.op;
        opb = d.op;
        arm_state = d.rst_at;
        arm_len = d.rst_len;
      end else begin
        pick = '{LW, SW, RT, BEQ, ADDI, JMP, rnd_op()};
        opa = pick[$urandom_range(0, 6)];
        opb = ($urandom_range(0, 4) == 0) ? rnd_op() : opa;
      end
      plan_instr(opa, opb);
    end
    op = plan[0].drv;
    reset = rst;
    if (rst) begin
      plan.delete();
      plan.push_back(step_t'{st: 0, drv: rnd_op()});
    end else begin
      void'(plan.pop_front());
      if (plan.size() == 0) plan.push_back(step_t'{st: 0, drv: rnd_op()});
    end
    sb.push_back(exp_t'{st: plan[0].st, cw: exp_cw(plan[0].st, rst)});
  endtask

  initial begin : monitor
    exp_t e;
    logic [14:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord,
               memtoreg, regdst, alusrcb, pcsrc, aluop};
        checks++;
        if (state !== 4'(e.st)) begin
          errors++;
          $display("FAIL state: got %0d expected %0d at %0t", state, e.st, $time);
        end
        checks++;
        if (act !== e.cw) begin
          errors++;
          $display("FAIL ctrlword in state %0d: got %b expected %b at %0t",
                   e.st, act, e.cw, $time);
        end
      end
    end
  end

  initial begin : stimulus
    int budget;
    reset = 1'b1;
    op = '0;
    plan.push_back(step_t'{st: 0, drv: '0});
    sb.push_back(exp_t'{st: 0, cw: exp_cw(0, 1'b1)});
    dirq.push_back(dir_t'{op: LW,    rst_at: -1, rst_len: 0});
    dirq.push_back(dir_t'{op: RT,    rst_at: -1, rst_len: 0});
    dirq.push_back(dir_t'{op: BEQ,   rst_at: -1, rst_len: 0});
    dirq.push_back(dir_t'{op: JMP,   rst_at: -1, rst_len: 0});
    dirq.push_back(dir_t'{op: 6'h3F, rst_at: -1, rst_len: 0});
    dirq.push_back(dir_t'{op: SW,    rst_at: 2,  rst_len: 1});
    dirq.push_back(dir_t'{op: SW,    rst_at: 5,  rst_len: 2});
    dirq.push_back(dir_t'{op: ADDI,  rst_at: -1, rst_len: 0});
    rst_left = 1;
    for (int i = 0; i < 60; i++) one_cycle();
    random_rst = 1'b1;
    for (int i = 0; i < 2500; i++) one_cycle();
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
